// File: rtl/noc_pkg.sv
// Shared NoC types: flit layout, receive FSM states and status counter width.
package noc_pkg;
    localparam int ERR_CNT_W    = 16;
    localparam int NOC_FLIT_W   = 32;
    localparam int NOC_ADDR_W   = 8;
    localparam int NOC_CREDIT_W = 4;

    typedef struct packed {
        logic [NOC_FLIT_W-1:0] data;
        logic [NOC_ADDR_W-1:0] src;
        logic [NOC_ADDR_W-1:0] dst;
        logic                  head;
        logic                  tail;
    } noc_flit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } noc_rx_state_e;
endpackage

// File: rtl/noc_if.sv
// Flit link between a router and an endpoint, with credit return path.
interface noc_if #(
    parameter int FLIT_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    import noc_pkg::*;

    logic                    flit_valid;
    logic [FLIT_WIDTH-1:0]   flit_data;
    logic [ADDR_WIDTH-1:0]   src_addr;
    logic [ADDR_WIDTH-1:0]   dst_addr;
    logic                    head_flit;
    logic                    tail_flit;
    logic                    flit_ready;
    logic                    credit_valid;
    logic [NOC_CREDIT_W-1:0] credit_count;

    modport receiver (
        input  flit_valid, flit_data, src_addr, dst_addr, head_flit, tail_flit,
        output flit_ready, credit_valid, credit_count
    );

    modport sender (
        output flit_valid, flit_data, src_addr, dst_addr, head_flit, tail_flit,
        input  flit_ready, credit_valid, credit_count
    );
endinterface

// File: rtl/noc_flit_fifo.sv
// Synchronous FIFO with registered pointers; read data is the current head entry.
module noc_flit_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  T                 wr_data,
    input  logic             pop,
    output T                 rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    T               mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
endmodule

// File: rtl/noc_rx_endpoint.sv
// NoC receive endpoint: buffers flits, filters by destination, checks framing, returns credits.
//   state | meaning
//   IDLE  | waiting for a head flit at the FIFO front
//   FWD   | forwarding body flits of a local packet
//   DROP  | silently discarding the rest of a non-local packet
module noc_rx_endpoint
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int LOCAL_ADDR   = 0,
    parameter int FIFO_DEPTH   = 8,
    parameter int CREDIT_BATCH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    noc_if.receiver               noc,
    output logic                  pkt_valid,
    input  logic                  pkt_ready,
    output logic [FLIT_WIDTH-1:0] pkt_data,
    output logic [ADDR_WIDTH-1:0] pkt_src,
    output logic                  pkt_first,
    output logic                  pkt_last,
    output logic                  pkt_abort,
    output logic [ERR_CNT_W-1:0]  err_misroute_cnt,
    output logic [ERR_CNT_W-1:0]  err_framing_cnt
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] src;
        logic [ADDR_WIDTH-1:0] dst;
        logic                  head;
        logic                  tail;
    } flit_t;

    flit_t             wr_flit;
    flit_t             hd;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  count_next;
    logic              push;
    logic              pop;

    noc_rx_state_e     state;
    noc_rx_state_e     state_next;
    logic              vld;
    logic              first;
    logic              last;
    logic              abort;
    logic              frm_inc;
    logic              mis_inc;
    logic [ADDR_WIDTH-1:0]   src_q;
    logic [NOC_CREDIT_W-1:0] acc;
    logic [NOC_CREDIT_W-1:0] next_acc;
    logic                    credit_valid_q;
    logic [NOC_CREDIT_W-1:0] credit_count_q;

    assign wr_flit = '{data: noc.flit_data, src: noc.src_addr, dst: noc.dst_addr,
                       head: noc.head_flit, tail: noc.tail_flit};
    assign noc.flit_ready = rst_n && !fifo_full;
    assign push = noc.flit_valid && noc.flit_ready;

    noc_flit_fifo #(.T(flit_t), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (wr_flit),
        .pop     (pop),
        .rd_data (hd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        pop        = 1'b0;
        vld        = 1'b0;
        first      = 1'b0;
        last       = 1'b0;
        abort      = 1'b0;
        frm_inc    = 1'b0;
        mis_inc    = 1'b0;
        state_next = state;
        if (!fifo_empty) begin
            unique case (state)
                IDLE: begin
                    if (!hd.head) begin
                        pop     = 1'b1;
                        frm_inc = 1'b1;
                    end else if (hd.dst != ADDR_WIDTH'(LOCAL_ADDR)) begin
                        pop     = 1'b1;
                        mis_inc = 1'b1;
                        if (!hd.tail) state_next = DROP;
                    end else begin
                        vld   = 1'b1;
                        first = 1'b1;
                        last  = hd.tail;
                        pop   = pkt_ready;
                        if (pkt_ready && !hd.tail) state_next = FWD;
                    end
                end
                FWD: begin
                    // A new head while forwarding truncates the packet; the head stays queued.
                    if (hd.head) begin
                        abort      = 1'b1;
                        frm_inc    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        vld  = 1'b1;
                        last = hd.tail;
                        pop  = pkt_ready;
                        if (pkt_ready && hd.tail) state_next = IDLE;
                    end
                end
                DROP: begin
                    if (hd.head) begin
                        state_next = IDLE;
                    end else begin
                        pop = 1'b1;
                        if (hd.tail) state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign next_acc   = acc + NOC_CREDIT_W'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            src_q            <= '0;
            err_misroute_cnt <= '0;
            err_framing_cnt  <= '0;
            acc              <= '0;
            credit_valid_q   <= 1'b0;
            credit_count_q   <= '0;
        end else begin
            state <= state_next;
            if (vld && first && pkt_ready) src_q <= hd.src;
            if (mis_inc && err_misroute_cnt != '1) err_misroute_cnt <= err_misroute_cnt + 1'b1;
            if (frm_inc && err_framing_cnt != '1)  err_framing_cnt  <= err_framing_cnt + 1'b1;
            // Flush a partial batch once the buffer drains so no credit is stranded.
            if (next_acc >= NOC_CREDIT_W'(CREDIT_BATCH) || (next_acc != '0 && count_next == '0)) begin
                credit_valid_q <= 1'b1;
                credit_count_q <= next_acc;
                acc            <= '0;
            end else begin
                credit_valid_q <= 1'b0;
                acc            <= next_acc;
            end
        end
    end

    assign noc.credit_valid = credit_valid_q;
    assign noc.credit_count = credit_count_q;

    assign pkt_valid = vld;
    assign pkt_first = first;
    assign pkt_last  = last;
    assign pkt_abort = abort;
    assign pkt_data  = vld ? hd.data : '0;
    assign pkt_src   = !vld ? '0 : (state == IDLE ? hd.src : src_q);
endmodule

// File: tb/tb_noc_rx_endpoint.sv
// Self-checking bench for noc_rx_endpoint: directed cases plus randomized traffic against a packet-level model.
module tb_noc_rx_endpoint;
    import noc_pkg::*;

    localparam int FW = 32, AW = 8, DEPTH = 8, BATCH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pkt_valid, pkt_ready, pkt_first, pkt_last, pkt_abort;
    logic [FW-1:0] pkt_data;
    logic [AW-1:0] pkt_src;
    logic [15:0]   err_misroute_cnt, err_framing_cnt;

    noc_if #(.FLIT_WIDTH(FW), .ADDR_WIDTH(AW)) link ();

    noc_rx_endpoint #(
        .FLIT_WIDTH(FW), .ADDR_WIDTH(AW), .LOCAL_ADDR(0),
        .FIFO_DEPTH(DEPTH), .CREDIT_BATCH(BATCH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .noc              (link),
        .pkt_valid        (pkt_valid),
        .pkt_ready        (pkt_ready),
        .pkt_data         (pkt_data),
        .pkt_src          (pkt_src),
        .pkt_first        (pkt_first),
        .pkt_last         (pkt_last),
        .pkt_abort        (pkt_abort),
        .err_misroute_cnt (err_misroute_cnt),
        .err_framing_cnt  (err_framing_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Packet-level reference: each accepted flit is classified in arrival order.
    typedef struct {
        bit          abort;
        logic [31:0] data;
        logic [7:0]  src;
        bit          first;
        bit          last;
    } exp_t;

    exp_t        expq[$];
    int          cq[$];
    int          pushed = 0, returned = 0, aborts_seen = 0;
    int          m_mis = 0, m_frm = 0;
    bit          m_in_pkt = 0, m_dropping = 0;
    logic [7:0]  m_src = '0;
    bit          prev_hold = 0;
    logic [31:0] prev_data = '0;

    function automatic int sat(input int c);
        return (c < 65535) ? c + 1 : c;
    endfunction

    function automatic void add_exp(input bit ab, input logic [31:0] d, input logic [7:0] s,
                                    input bit f, input bit l);
        exp_t e;
        e.abort = ab; e.data = d; e.src = s; e.first = f; e.last = l;
        expq.push_back(e);
    endfunction

    function automatic void model_flit(input logic [31:0] d, input logic [7:0] s,
                                       input logic [7:0] dst, input bit h, input bit t);
        if (m_dropping) begin
            if (!h) begin
                if (t) m_dropping = 0;
                return;
            end
            m_dropping = 0;
        end
        if (m_in_pkt) begin
            if (h) begin
                add_exp(1, '0, '0, 0, 0);
                m_frm = sat(m_frm);
                m_in_pkt = 0;
            end else begin
                add_exp(0, d, m_src, 0, t);
                if (t) m_in_pkt = 0;
                return;
            end
        end
        if (!h) begin
            m_frm = sat(m_frm);
        end else if (dst != 8'h00) begin
            m_mis = sat(m_mis);
            m_dropping = !t;
        end else begin
            m_src = s;
            add_exp(0, d, s, 1, t);
            m_in_pkt = !t;
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            expq.delete();
            pushed = 0; returned = 0;
            m_mis = 0; m_frm = 0; m_in_pkt = 0; m_dropping = 0;
            prev_hold = 0;
        end else begin
            if (prev_hold) chk("pkt_hold", {pkt_valid, pkt_data}, {1'b1, prev_data});
            prev_hold = pkt_valid && !pkt_ready;
            prev_data = pkt_data;
            if (pkt_abort) begin
                aborts_seen++;
                chk("abort_expected", expq.size() > 0 && expq[0].abort, 1);
                if (expq.size() > 0 && expq[0].abort) void'(expq.pop_front());
            end
            if (pkt_valid && pkt_ready) begin
                chk("pkt_expected", expq.size() > 0 && !expq[0].abort, 1);
                if (expq.size() > 0 && !expq[0].abort) begin
                    e = expq.pop_front();
                    chk("pkt_data", pkt_data, e.data);
                    chk("pkt_src", pkt_src, e.src);
                    chk("pkt_first_last", {pkt_first, pkt_last}, {e.first, e.last});
                end
            end
            if (link.credit_valid) begin
                returned += int'(link.credit_count);
                cq.push_back(int'(link.credit_count));
                chk("credit_range", link.credit_count >= 1 && link.credit_count <= BATCH, 1);
                chk("credit_not_ahead", returned <= pushed, 1);
            end
            if (link.flit_valid && link.flit_ready) begin
                pushed++;
                model_flit(link.flit_data, link.src_addr, link.dst_addr, link.head_flit, link.tail_flit);
            end
        end
    end

    // Entered and left at posedge+1.
    task automatic send(input logic [31:0] d, input logic [7:0] s, input logic [7:0] dst,
                        input bit h, input bit t);
        int n = 0;
        link.flit_valid = 1'b1;
        link.flit_data  = d;
        link.src_addr   = s;
        link.dst_addr   = dst;
        link.head_flit  = h;
        link.tail_flit  = t;
        @(negedge clk);
        while (!link.flit_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", link.flit_ready, 1);
        @(posedge clk);
        #1;
        link.flit_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        pkt_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        while ((expq.size() != 0 || returned != pushed) && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_credits", returned, pushed);
        chk("drain_expq", expq.size(), 0);
        chk("err_misroute_cnt", err_misroute_cnt, m_mis);
        chk("err_framing_cnt", err_framing_cnt, m_frm);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_phase();
        bit          stop;
        int          kind, len, gap;
        logic [7:0]  s, dst;
        stop = 0;
        fork
            begin
                for (int p = 0; p < 300; p++) begin
                    kind = $urandom_range(0, 9);
                    len  = $urandom_range(1, 4);
                    s    = 8'($urandom);
                    dst  = (kind == 2 || kind == 3) ? 8'($urandom_range(1, 255)) : 8'h00;
                    if (kind == 0) begin
                        send($urandom, s, dst, 0, 1'($urandom_range(0, 1)));
                    end else begin
                        for (int i = 0; i < len; i++)
                            send($urandom, s, dst, i == 0, (i == len - 1) && kind != 1);
                    end
                    gap = $urandom_range(0, 2);
                    repeat (gap) begin
                        @(posedge clk);
                        #1;
                    end
                end
                send(32'h600D_0001, 8'h3C, 8'h00, 1, 1);
                stop = 1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    pkt_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0, a0, f0;
        link.flit_valid = 1'b0;
        link.flit_data  = '0;
        link.src_addr   = '0;
        link.dst_addr   = '0;
        link.head_flit  = 1'b0;
        link.tail_flit  = 1'b0;
        pkt_ready       = 1'b0;
        rst_n           = 1'b0;

        #12;
        chk("rst_flit_ready", link.flit_ready, 0);
        chk("rst_credit", {link.credit_valid, link.credit_count}, 0);
        chk("rst_pkt_ctl", {pkt_valid, pkt_first, pkt_last, pkt_abort}, 0);
        chk("rst_pkt_data_src", {pkt_data, pkt_src}, 0);
        chk("rst_err_cnts", {err_misroute_cnt, err_framing_cnt}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("flit_ready_after_rst", link.flit_ready, 1);

        // Single-flit local packet: visible the cycle after accept, credit 1 after pop.
        pkt_ready = 1'b1;
        send(32'hA5A5_0001, 8'h11, 8'h00, 1, 1);
        @(negedge clk);
        chk("single_valid_first_last", {pkt_valid, pkt_first, pkt_last}, 3'b111);
        chk("single_data", pkt_data, 32'hA5A5_0001);
        chk("single_src", pkt_src, 8'h11);
        @(negedge clk);
        chk("single_credit", {link.credit_valid, link.credit_count}, {1'b1, 4'd1});
        @(posedge clk);
        #1;
        drain();

        // Fill the buffer with the consumer stalled, then release it.
        pkt_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(32'hB000_0000 + i, 8'h22, 8'h00, i == 0, i == 7);
        @(negedge clk);
        chk("full_flit_ready", link.flit_ready, 0);
        chk("full_head_waiting", {pkt_valid, pkt_first}, 2'b11);
        @(posedge clk);
        #1;
        cq.delete();
        drain();
        chk("batch_pulses", cq.size(), 2);
        chk("batch_first", cq.size() > 0 ? cq[0] : 0, 4);
        chk("batch_second", cq.size() > 1 ? cq[1] : 0, 4);

        // Misrouted 3-flit packet.
        r0 = returned;
        send(32'hC000_0001, 8'h33, 8'h05, 1, 0);
        send(32'hC000_0002, 8'h33, 8'h05, 0, 0);
        send(32'hC000_0003, 8'h33, 8'h05, 0, 1);
        drain();
        chk("misroute_cnt", err_misroute_cnt, 1);
        chk("misroute_credits", returned - r0, 3);

        // Head, body, then a new head: abort, then the second packet delivered.
        a0 = aborts_seen;
        send(32'hD000_0001, 8'h44, 8'h00, 1, 0);
        send(32'hD000_0002, 8'h44, 8'h00, 0, 0);
        send(32'hD000_0003, 8'h55, 8'h00, 1, 1);
        drain();
        chk("abort_pulses", aborts_seen - a0, 1);
        chk("abort_framing_cnt", err_framing_cnt, 1);

        rand_phase();
        drain();

        // Orphan body flits, then enough to saturate the framing counter.
        f0 = m_frm;
        send(32'hE000_0001, 8'h66, 8'h00, 0, 0);
        drain();
        chk("orphan_one", err_framing_cnt, sat(f0));
        for (int i = 0; i < 65540; i++) send($urandom, 8'h77, 8'h00, 0, i[0]);
        drain();
        chk("framing_saturated", err_framing_cnt, 16'hFFFF);

        // Reset with three flits buffered mid-packet.
        pkt_ready = 1'b0;
        send(32'hF000_0001, 8'h12, 8'h00, 1, 0);
        send(32'hF000_0002, 8'h12, 8'h00, 0, 0);
        send(32'hF000_0003, 8'h12, 8'h00, 0, 0);
        @(negedge clk);
        chk("pre_rst_valid", pkt_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_flit_ready", link.flit_ready, 0);
        chk("async_rst_credit", {link.credit_valid, link.credit_count}, 0);
        chk("async_rst_pkt_ctl", {pkt_valid, pkt_first, pkt_last, pkt_abort}, 0);
        chk("async_rst_pkt_data_src", {pkt_data, pkt_src}, 0);
        chk("async_rst_err_cnts", {err_misroute_cnt, err_framing_cnt}, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pkt_ready = 1'b1;
        send(32'h1234_0001, 8'h21, 8'h00, 1, 0);
        send(32'h1234_0002, 8'h21, 8'h00, 0, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
